// File: rtl/c4_game_ctrl.sv
// ---------------------------------------------------------------------------
// c4_game_ctrl
// Game sequencer for the Connect-Four VGA display. Owns the board, the drop
// cursor and the turn bit rendered by the pixel stage. Button pulses move
// the cursor or drop a piece into the lowest free cell of the cursor column.
// After every placement the four line directions through the new piece are
// checked for a win. A full board without a win is a draw.
//
// Ports
//   clk        system/pixel clock
//   rst        asynchronous active-low reset
//   btn_left   one-cycle pulse, cursor one column left (saturating)
//   btn_right  one-cycle pulse, cursor one column right (saturating)
//   btn_drop   one-cycle pulse, drop a piece in the cursor column
//   new_game   one-cycle pulse, synchronous clear (highest priority)
//   panel      board cells [row][col]: 00 empty, 01 red, 10 green
//              row 0 = bottom, col 6 = leftmost
//   play       one-hot cursor, bit 6 = leftmost column, 0 in DONE
//   player     side to move: 0 red, 1 green
//   busy       high while a drop is being processed
//   game_over  high once the game has ended
//   winner     00 none, 01 red, 10 green, 11 draw
//   fsm_state  current controller state, for observation
//
// Input semantics: the buttons are single-cycle pulses with no handshake.
// A pulse is acted on only in the cycle where it is high and the controller
// is in IDLE. It is discarded otherwise, so nothing is ever queued.
// ---------------------------------------------------------------------------
module c4_game_ctrl #(
   parameter int WIN_LEN      = 4,
   parameter int START_COL    = 3,
   parameter bit FIRST_PLAYER = 1'b0
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 btn_left,
   input  logic                 btn_right,
   input  logic                 btn_drop,
   input  logic                 new_game,
   output logic [5:0][6:0][1:0] panel,
   output logic [6:0]           play,
   output logic                 player,
   output logic                 busy,
   output logic                 game_over,
   output logic [1:0]           winner,
   output logic [2:0]           fsm_state
);

   localparam logic [6:0] PLAY_START = 7'(1 << START_COL);

   typedef enum logic [2:0] {
      S_IDLE  = 3'd0,
      S_SCAN  = 3'd1,
      S_PLACE = 3'd2,
      S_CHECK = 3'd3,
      S_NEXT  = 3'd4,
      S_DONE  = 3'd5
   } state_t;

   state_t     state;
   state_t     state_next;

   logic [2:0] row;          // row under test / row being written
   logic [2:0] col;          // column latched at the drop
   logic [1:0] dir;          // line direction under test in CHECK
   logic [5:0] move_count;
   logic       win_flag;

   logic [2:0] cursor_col;
   logic [1:0] colour;
   logic       cell_empty;
   logic [2:0] run_len;
   logic       run_win;
   logic       pos_ok;
   logic       neg_ok;
   int         dr;
   int         dc;

   assign fsm_state  = state;
   assign colour     = player ? 2'b10 : 2'b01;
   assign cell_empty = (panel[row][col] == 2'b00);

   // True when (r, c) lies on the board and holds the given colour.
   // Off-board positions never match, which ends a run at the edge.
   function automatic logic cell_is(input logic [5:0][6:0][1:0] board,
                                    input int r, input int c,
                                    input logic [1:0] colour_in);
      logic hit;
      hit = 1'b0;
      if (r >= 0 && r <= 5 && c >= 0 && c <= 6)
         hit = (board[3'(r)][3'(c)] == colour_in);
      return hit;
   endfunction

   // Column index of the one-hot cursor.
   always_comb begin
      cursor_col = 3'd0;
      for (int i = 0; i < 7; i++)
         if (play[i]) cursor_col = 3'(i);
   end

   // Run length through the newly placed piece along direction dir:
   // 0 horizontal, 1 vertical, 2 up with rising column index,
   // 3 up with falling column index. Each side stops at the first mismatch.
   always_comb begin
      dr      = 0;
      dc      = 1;
      pos_ok  = 1'b1;
      neg_ok  = 1'b1;
      run_len = 3'd1;
      unique case (dir)
         2'd0:    begin dr = 0; dc = 1;  end
         2'd1:    begin dr = 1; dc = 0;  end
         2'd2:    begin dr = 1; dc = 1;  end
         default: begin dr = 1; dc = -1; end
      endcase
      for (int k = 1; k <= 3; k++) begin
         pos_ok = pos_ok && cell_is(panel, int'(row) + k * dr, int'(col) + k * dc, colour);
         neg_ok = neg_ok && cell_is(panel, int'(row) - k * dr, int'(col) - k * dc, colour);
         if (pos_ok) run_len = run_len + 3'd1;
         if (neg_ok) run_len = run_len + 3'd1;
      end
   end

   assign run_win = (int'(run_len) >= WIN_LEN);

   // State register
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) state <= S_IDLE;
      else      state <= state_next;
   end

   // Next-state logic
   always_comb begin
      state_next = state;
      unique case (state)
         S_IDLE:  if (btn_drop) state_next = S_SCAN;
         S_SCAN: begin
            if (cell_empty)         state_next = S_PLACE;
            else if (row == 3'd5)   state_next = S_IDLE;   // column full
         end
         S_PLACE: state_next = S_CHECK;
         S_CHECK: if (dir == 2'd3) state_next = S_NEXT;
         S_NEXT: begin
            if (win_flag || move_count == 6'd42) state_next = S_DONE;
            else                                 state_next = S_IDLE;
         end
         S_DONE:  state_next = S_DONE;
         default: state_next = S_IDLE;
      endcase
      if (new_game) state_next = S_IDLE;
   end

   // Datapath and registered status outputs
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         panel      <= '0;
         play       <= PLAY_START;
         player     <= FIRST_PLAYER;
         busy       <= 1'b0;
         game_over  <= 1'b0;
         winner     <= 2'b00;
         move_count <= 6'd0;
         row        <= 3'd0;
         col        <= 3'd0;
         dir        <= 2'd0;
         win_flag   <= 1'b0;
      end else begin
         // Status flags follow the state being entered so they are
         // registered and aligned with it.
         busy      <= (state_next == S_SCAN)  || (state_next == S_PLACE) ||
                      (state_next == S_CHECK) || (state_next == S_NEXT);
         game_over <= (state_next == S_DONE);
         if (new_game) begin
            panel      <= '0;
            play       <= PLAY_START;
            player     <= FIRST_PLAYER;
            winner     <= 2'b00;
            move_count <= 6'd0;
            row        <= 3'd0;
            col        <= 3'd0;
            dir        <= 2'd0;
            win_flag   <= 1'b0;
         end else begin
            unique case (state)
               S_IDLE: begin
                  if (btn_drop) begin
                     col <= cursor_col;
                     row <= 3'd0;
                  end else if (btn_left) begin
                     if (!play[6]) play <= play << 1;
                  end else if (btn_right) begin
                     if (!play[0]) play <= play >> 1;
                  end
               end
               S_SCAN: begin
                  if (!cell_empty && row != 3'd5) row <= row + 3'd1;
               end
               S_PLACE: begin
                  panel[row][col] <= colour;
                  move_count      <= move_count + 6'd1;
                  dir             <= 2'd0;
                  win_flag        <= 1'b0;
               end
               S_CHECK: begin
                  if (run_win) win_flag <= 1'b1;
                  dir <= dir + 2'd1;
               end
               S_NEXT: begin
                  if (win_flag) begin
                     winner <= colour;
                     play   <= 7'd0;
                  end else if (move_count == 6'd42) begin
                     winner <= 2'b11;
                     play   <= 7'd0;
                  end else begin
                     player <= ~player;
                  end
               end
               default: ;
            endcase
         end
      end
   end

endmodule

// File: tb/tb_c4_game_ctrl.sv
// ---------------------------------------------------------------------------
// tb_c4_game_ctrl
// Bench for c4_game_ctrl. A game-level model decides each drop's outcome at
// the moment the drop is accepted. It finds the landing row as the lowest
// empty cell and scans the whole board for four in a line. It then plays the
// result out on a countdown derived from the drop latency. A compare process
// checks every DUT output against that model on every falling clock edge.
// Directed scenarios add literal expectations on top.
// ---------------------------------------------------------------------------
module tb_c4_game_ctrl;

  logic                 clk;
  logic                 rst;
  logic                 btn_left;
  logic                 btn_right;
  logic                 btn_drop;
  logic                 new_game;
  logic [5:0][6:0][1:0] panel;
  logic [6:0]           play;
  logic                 player;
  logic                 busy;
  logic                 game_over;
  logic [1:0]           winner;
  logic [2:0]           fsm_state;

  int n_tests = 0;
  int n_fail  = 0;
  int n_print = 0;
  logic checking = 1'b0;

  c4_game_ctrl dut (
    .clk       (clk),
    .rst       (rst),
    .btn_left  (btn_left),
    .btn_right (btn_right),
    .btn_drop  (btn_drop),
    .new_game  (new_game),
    .panel     (panel),
    .play      (play),
    .player    (player),
    .busy      (busy),
    .game_over (game_over),
    .winner    (winner),
    .fsm_state (fsm_state)
  );

  // ---------------- clock ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- game-level model ----------------
  logic [5:0][6:0][1:0] m_panel;
  logic [6:0]           m_play;
  logic                 m_player;
  logic [1:0]           m_winner;
  logic                 m_over;
  int                   m_count;
  int                   m_remaining;   // cycles of busy still to come
  int                   m_tr;          // landing row, -1 for a full column
  int                   m_tc;

  function automatic logic [1:0] piece(input logic p);
    return p ? 2'b10 : 2'b01;
  endfunction

  function automatic int onehot_idx(input logic [6:0] v);
    int idx;
    idx = 0;
    for (int i = 0; i < 7; i++) if (v[i]) idx = i;
    return idx;
  endfunction

  function automatic int lowest_free(input logic [5:0][6:0][1:0] b, input int c);
    for (int r = 0; r < 6; r++) if (b[r][c] == 2'b00) return r;
    return -1;
  endfunction

  // Any four-in-a-line of colour c anywhere on the board.
  function automatic logic has_win(input logic [5:0][6:0][1:0] b, input logic [1:0] c);
    int drs[4];
    int dcs[4];
    drs = '{0, 1, 1, 1};
    dcs = '{1, 0, 1, -1};
    for (int r = 0; r < 6; r++)
      for (int cc = 0; cc < 7; cc++)
        for (int d = 0; d < 4; d++) begin
          logic ok;
          ok = 1'b1;
          for (int k = 0; k < 4; k++) begin
            int rr;
            int cx;
            rr = r + k * drs[d];
            cx = cc + k * dcs[d];
            if (rr < 0 || rr > 5 || cx < 0 || cx > 6) ok = 1'b0;
            else if (b[rr][cx] != c) ok = 1'b0;
          end
          if (ok) return 1'b1;
        end
    return 1'b0;
  endfunction

  // A free landing row r gives r+1 scan cycles, one place cycle, four check
  // cycles and one resolve cycle. The piece becomes visible r+2 edges after
  // the drop, which is always 5 edges before the end. A full column costs
  // six scan cycles and changes nothing.
  always @(posedge clk or negedge rst) begin
    if (!rst || new_game) begin
      m_panel     <= '0;
      m_play      <= 7'b0001000;
      m_player    <= 1'b0;
      m_winner    <= 2'b00;
      m_over      <= 1'b0;
      m_count     <= 0;
      m_remaining <= 0;
      m_tr        <= -1;
      m_tc        <= 0;
    end else if (m_remaining != 0) begin
      m_remaining <= m_remaining - 1;
      if (m_tr >= 0 && m_remaining == 6) begin
        m_panel[m_tr][m_tc] <= piece(m_player);
        m_count             <= m_count + 1;
      end
      if (m_tr >= 0 && m_remaining == 1) begin
        if (has_win(m_panel, piece(m_player))) begin
          m_winner <= piece(m_player);
          m_over   <= 1'b1;
          m_play   <= 7'd0;
        end else if (m_count == 42) begin
          m_winner <= 2'b11;
          m_over   <= 1'b1;
          m_play   <= 7'd0;
        end else begin
          m_player <= !m_player;
        end
      end
    end else if (!m_over) begin
      if (btn_drop) begin
        m_tc        <= onehot_idx(m_play);
        m_tr        <= lowest_free(m_panel, onehot_idx(m_play));
        m_remaining <= (lowest_free(m_panel, onehot_idx(m_play)) < 0) ? 6 :
                       lowest_free(m_panel, onehot_idx(m_play)) + 7;
      end else if (btn_left) begin
        if (m_play != 7'b1000000) m_play <= m_play << 1;
      end else if (btn_right) begin
        if (m_play != 7'b0000001) m_play <= m_play >> 1;
      end
    end
  end

  // ---------------- per-cycle compare ----------------
  always @(negedge clk) begin
    if (checking) begin
      n_tests++;
      if (busy !== (m_remaining != 0) || game_over !== m_over || winner !== m_winner ||
          player !== m_player || play !== m_play || panel !== m_panel) begin
        n_fail++;
        if (n_print < 30) begin
          n_print++;
          $display("FAIL cycle_compare t=%0t got busy=%b over=%b winner=%b player=%b play=%b panel=%h want busy=%b over=%b winner=%b player=%b play=%b panel=%h",
                   $time, busy, game_over, winner, player, play, panel,
                   (m_remaining != 0), m_over, m_winner, m_player, m_play, m_panel);
        end
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s got=%h want=%h", name, act, exp);
    end
  endtask

  // which: 0 left, 1 right, 2 drop, 3 new_game
  task automatic pulse(input int which);
    @(posedge clk);
    #1;
    case (which)
      0:       btn_left  = 1'b1;
      1:       btn_right = 1'b1;
      2:       btn_drop  = 1'b1;
      default: new_game  = 1'b1;
    endcase
    @(posedge clk);
    #1;
    btn_left  = 1'b0;
    btn_right = 1'b0;
    btn_drop  = 1'b0;
    new_game  = 1'b0;
  endtask

  task automatic measure_busy(output int cycles);
    cycles = 0;
    @(negedge clk);
    while (busy === 1'b1 && cycles < 100) begin
      cycles++;
      @(negedge clk);
    end
    if (cycles >= 100) begin
      n_tests++;
      n_fail++;
      $display("FAIL busy_timeout got=%0d cycles want=<100", cycles);
    end
  endtask

  task automatic drop_at(input int c, output int cycles);
    for (int i = 0; i < 7; i++) pulse(1);
    for (int i = 0; i < c; i++) pulse(0);
    pulse(2);
    measure_busy(cycles);
  endtask

  // ---------------- directed scenarios ----------------
  initial begin
    int cyc;
    int t4_cols[7];
    int diag_cols[10];
    int vert_cols[7];
    int pair_x[3];
    int pair_y[3];
    logic [5:0][6:0][1:0] exp_col;

    t4_cols   = '{0, 6, 1, 6, 2, 6, 3};
    diag_cols = '{1, 0, 2, 1, 2, 2, 3, 3, 3, 3};
    vert_cols = '{0, 1, 0, 1, 0, 1, 0};
    pair_x    = '{1, 4, 5};
    pair_y    = '{2, 3, 6};

    rst       = 1'b1;
    btn_left  = 1'b0;
    btn_right = 1'b0;
    btn_drop  = 1'b0;
    new_game  = 1'b0;
    #3 rst = 1'b0;
    checking = 1'b1;
    repeat (3) @(posedge clk);
    #2 rst = 1'b1;
    chk("reset_play",   128'(play), 128'(7'b0001000));
    chk("reset_panel",  128'(panel), 128'(0));
    chk("reset_winner", 128'({busy, game_over, winner, player}), 128'(0));

    // 1: bottom-row drop in the centre column
    pulse(2);
    measure_busy(cyc);
    chk("t1_busy_cycles", 128'(cyc), 128'(7));
    chk("t1_cell_0_3", 128'(panel[0][3]), 128'(2'b01));
    chk("t1_player", 128'(player), 128'(1));

    // 2: cursor saturation
    pulse(3);
    for (int i = 0; i < 5; i++) pulse(0);
    chk("t2_left_sat", 128'(play), 128'(7'b1000000));
    for (int i = 0; i < 8; i++) pulse(1);
    chk("t2_right_sat", 128'(play), 128'(7'b0000001));

    // 3: fill column 3, then drop into the full column
    pulse(3);
    for (int i = 0; i < 6; i++) drop_at(3, cyc);
    chk("t3_cell_5_3", 128'(panel[5][3]), 128'(2'b10));
    drop_at(3, cyc);
    exp_col = '0;
    for (int r = 0; r < 6; r++) exp_col[r][3] = (r % 2 == 1) ? 2'b10 : 2'b01;
    chk("t3_full_cycles", 128'(cyc), 128'(6));
    chk("t3_full_panel", 128'(panel), 128'(exp_col));
    chk("t3_full_player", 128'(player), 128'(0));

    // 4: horizontal red win, buttons ignored afterwards, then new_game
    pulse(3);
    for (int i = 0; i < 7; i++) drop_at(t4_cols[i], cyc);
    chk("t4_winner", 128'(winner), 128'(2'b01));
    chk("t4_over", 128'(game_over), 128'(1));
    chk("t4_play", 128'(play), 128'(0));
    pulse(2);
    pulse(0);
    pulse(1);
    repeat (3) @(negedge clk);
    chk("t4_ignored", 128'({busy, play, winner}), 128'({1'b0, 7'd0, 2'b01}));
    pulse(3);
    chk("t4_new_panel", 128'(panel), 128'(0));
    chk("t4_new_status", 128'({play, player, busy, game_over, winner}),
        128'({7'b0001000, 1'b0, 1'b0, 1'b0, 2'b00}));

    // 5: green diagonal win, then red vertical win
    pulse(3);
    for (int i = 0; i < 10; i++) drop_at(diag_cols[i], cyc);
    chk("t5_diag_winner", 128'(winner), 128'(2'b10));
    chk("t5_diag_over", 128'(game_over), 128'(1));
    pulse(3);
    for (int i = 0; i < 7; i++) drop_at(vert_cols[i], cyc);
    chk("t5_vert_winner", 128'(winner), 128'(2'b01));
    chk("t5_vert_cell", 128'(panel[3][0]), 128'(2'b01));

    // 6: full board with no line of four
    pulse(3);
    for (int i = 0; i < 6; i++) drop_at(0, cyc);
    for (int p = 0; p < 3; p++)
      for (int i = 0; i < 12; i++)
        drop_at(((i % 4 == 0) || (i % 4 == 3)) ? pair_x[p] : pair_y[p], cyc);
    chk("t6_draw_winner", 128'(winner), 128'(2'b11));
    chk("t6_draw_status", 128'({game_over, play}), 128'({1'b1, 7'd0}));
    chk("t6_cell_5_6", 128'(panel[5][6]), 128'(2'b01));
    chk("t6_cell_0_2", 128'(panel[0][2]), 128'(2'b10));

    // 6b: asynchronous reset in the middle of a scan
    pulse(3);
    for (int i = 0; i < 3; i++) drop_at(3, cyc);
    pulse(2);
    @(posedge clk);
    #2 rst = 1'b0;
    #1;
    chk("t6_async_panel", 128'(panel), 128'(0));
    chk("t6_async_status", 128'({busy, play, player}), 128'({1'b0, 7'b0001000, 1'b0}));
    @(posedge clk);
    #2 rst = 1'b1;
    drop_at(3, cyc);
    chk("t6_after_reset_cycles", 128'(cyc), 128'(7));

    repeat (3) @(negedge clk);
    checking = 1'b0;
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
